// File: rtl/regfile_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_writeback_ctrl
//
// Owns the single write port of a 32 x XLEN RISC-V register file (x0 is
// hardwired to zero). ALU results and in-order load responses are merged onto
// that port, and a busy scoreboard stalls issue on RAW/WAW hazards.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   issue_valid         decoded instruction presented
//   issue_rs0/rs1/rd    source and destination register numbers
//   issue_writes_rd     instruction writes rd
//   issue_is_load       instruction is a load (data returns via ld_resp_*)
//   issue_ready         issue accepted when issue_valid & issue_ready
//   alu_valid/rd/data   ALU writeback, always accepted, highest priority
//   ld_resp_valid/data  load response, accepted when valid & ld_resp_ready
//   ld_resp_ready       load response may be consumed this cycle
//   wr_ena/addr/data    register file write port (lands on the next edge)
//   loads_outstanding   loads issued but not yet written back
//   idle                no busy registers and no outstanding loads
// -----------------------------------------------------------------------------
module regfile_writeback_ctrl #(
  parameter int LOAD_DEPTH = 4,
  parameter int XLEN       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_rs0,
  input  logic [4:0]                    issue_rs1,
  input  logic [4:0]                    issue_rd,
  input  logic                          issue_writes_rd,
  input  logic                          issue_is_load,
  output logic                          issue_ready,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          ld_resp_valid,
  input  logic [XLEN-1:0]               ld_resp_data,
  output logic                          ld_resp_ready,
  output logic                          wr_ena,
  output logic [4:0]                    wr_addr,
  output logic [XLEN-1:0]               wr_data,
  output logic [$clog2(LOAD_DEPTH):0]   loads_outstanding,
  output logic                          idle
);

  localparam int PTR_W = $clog2(LOAD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Scoreboard: bit r set while a write to xr is pending. Bit 0 is never set.
  logic [31:0]       busy;
  logic [31:0]       busy_next;

  // Load-destination FIFO. Each entry holds the destination register and a
  // flag saying whether the response must actually be written (loads to x0
  // or loads without a destination are still queued so the data is drained).
  logic [4:0]        fifo_rd [LOAD_DEPTH];
  logic              fifo_wr [LOAD_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              fifo_full;
  logic              fifo_empty;
  logic              issue_fire;
  logic              push;
  logic              push_wr;
  logic              ld_fire;
  logic              head_wr;
  logic [4:0]        head_rd;
  logic              alu_wr;

  assign fifo_full  = (count == CNT_W'(LOAD_DEPTH));
  assign fifo_empty = (count == {CNT_W{1'b0}});
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_wr    = fifo_wr[rd_ptr];

  // Issue acceptance looks only at registered state, so a register whose
  // busy bit clears on this edge still stalls issue for this cycle.
  assign issue_ready = !rst
                     && !busy[issue_rs0]
                     && !busy[issue_rs1]
                     && (!issue_writes_rd || !busy[issue_rd])
                     && (!issue_is_load || !fifo_full);

  assign issue_fire = issue_valid && issue_ready;
  assign push       = issue_fire && issue_is_load;
  assign push_wr    = issue_writes_rd && (issue_rd != 5'd0);

  // The ALU owns the write port whenever it is valid, even for x0.
  assign ld_resp_ready = !rst && !fifo_empty && !alu_valid;
  assign ld_fire       = ld_resp_valid && ld_resp_ready;
  assign alu_wr        = alu_valid && (alu_rd != 5'd0);

  assign loads_outstanding = count;
  assign idle              = (busy == 32'd0) && fifo_empty;

  // Write-port arbitration: ALU first, then the load at the FIFO head.
  always_comb begin
    wr_ena  = 1'b0;
    wr_addr = 5'd0;
    wr_data = {XLEN{1'b0}};
    if (rst) begin
      wr_ena = 1'b0;
    end else if (alu_wr) begin
      wr_ena  = 1'b1;
      wr_addr = alu_rd;
      wr_data = alu_data;
    end else if (ld_fire && head_wr) begin
      wr_ena  = 1'b1;
      wr_addr = head_rd;
      wr_data = ld_resp_data;
    end else begin
      wr_ena = 1'b0;
    end
  end

  // Scoreboard update: clear on writeback, set on issue. The WAW stall keeps
  // a clear and a set of the same register from meeting on one edge.
  always_comb begin
    busy_next = busy;
    if (alu_wr) begin
      busy_next[alu_rd] = 1'b0;
    end else begin
      busy_next = busy_next;
    end
    if (ld_fire && head_wr) begin
      busy_next[head_rd] = 1'b0;
    end else begin
      busy_next = busy_next;
    end
    if (issue_fire && push_wr) begin
      busy_next[issue_rd] = 1'b1;
    end else begin
      busy_next = busy_next;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

  // FIFO entry storage, written at the tail on a load issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOAD_DEPTH; i++) begin
        fifo_rd[i] <= 5'd0;
        fifo_wr[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_rd[wr_ptr] <= issue_rd;
      fifo_wr[wr_ptr] <= push_wr;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^n).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (ld_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, ld_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for regfile_writeback_ctrl: directed vector table,
// a hand-written asynchronous-reset sequence, then randomized traffic checked
// against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_regfile_writeback_ctrl;

  localparam int LD = 4;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [4:0]    issue_rs0, issue_rs1, issue_rd;
  logic          issue_writes_rd, issue_is_load;
  logic          issue_ready;
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [XL-1:0] alu_data;
  logic          ld_resp_valid;
  logic [XL-1:0] ld_resp_data;
  logic          ld_resp_ready;
  logic          wr_ena;
  logic [4:0]    wr_addr;
  logic [XL-1:0] wr_data;
  logic [2:0]    loads_outstanding;
  logic          idle;

  always #5 clk = ~clk;

  regfile_writeback_ctrl #(.LOAD_DEPTH(LD), .XLEN(XL)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs0(issue_rs0), .issue_rs1(issue_rs1),
    .issue_rd(issue_rd), .issue_writes_rd(issue_writes_rd),
    .issue_is_load(issue_is_load), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .ld_resp_ready(ld_resp_ready),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .loads_outstanding(loads_outstanding), .idle(idle)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] rd; bit wr; } lq_t;
  bit         m_busy [32];
  lq_t        m_q [$];
  int         alu_pend [$];
  bit         e_ir, e_lr, e_we, e_idle;
  logic [4:0] e_wa;
  logic [31:0] e_wd;
  int         e_lo;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_q.delete();
    alu_pend.delete();
  endtask

  task automatic model_eval();
    bit any;
    any = 1'b0;
    foreach (m_busy[i]) any |= m_busy[i];
    e_ir = !rst && !m_busy[issue_rs0] && !m_busy[issue_rs1]
           && (!issue_writes_rd || !m_busy[issue_rd])
           && (!issue_is_load || m_q.size() < LD);
    e_lr = !rst && (m_q.size() > 0) && !alu_valid;
    e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0;
    if (!rst && alu_valid && alu_rd != 5'd0) begin
      e_we = 1'b1; e_wa = alu_rd; e_wd = alu_data;
    end else if (!rst && ld_resp_valid && e_lr && m_q[0].wr) begin
      e_we = 1'b1; e_wa = m_q[0].rd; e_wd = ld_resp_data;
    end
    e_lo   = m_q.size();
    e_idle = !any && (m_q.size() == 0);
  endtask

  task automatic model_commit();
    int idx;
    if (rst) begin
      model_reset();
      return;
    end
    if (alu_valid && alu_rd != 5'd0) begin
      m_busy[alu_rd] = 1'b0;
      idx = -1;
      foreach (alu_pend[i]) if (alu_pend[i] == int'(alu_rd)) idx = i;
      if (idx >= 0) alu_pend.delete(idx);
    end
    if (ld_resp_valid && e_lr) begin
      if (m_q[0].wr) m_busy[m_q[0].rd] = 1'b0;
      void'(m_q.pop_front());
    end
    if (issue_valid && e_ir) begin
      if (issue_writes_rd && issue_rd != 5'd0) begin
        m_busy[issue_rd] = 1'b1;
        if (!issue_is_load) alu_pend.push_back(int'(issue_rd));
      end
      if (issue_is_load) m_q.push_back('{issue_rd, issue_writes_rd && issue_rd != 5'd0});
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iv;  logic [4:0] rs0; logic [4:0] rs1; logic [4:0] rd;
    logic        wrd; logic isld;
    logic        av;  logic [4:0] ard; logic [31:0] adata;
    logic        lv;  logic [31:0] ldata;
    logic        eir; logic elr; logic ewe; logic [4:0] ewa; logic [31:0] ewd;
    int          elo; logic eidle;
  } vec_t;

  function automatic vec_t mk(input int iv, input int rs0, input int rs1, input int rd,
                              input int wrd, input int isld,
                              input int av, input int ard, input logic [31:0] adata,
                              input int lv, input logic [31:0] ldata,
                              input int eir, input int elr, input int ewe, input int ewa,
                              input logic [31:0] ewd, input int elo, input int eidle);
    vec_t v;
    v.iv = 1'(iv); v.rs0 = 5'(rs0); v.rs1 = 5'(rs1); v.rd = 5'(rd);
    v.wrd = 1'(wrd); v.isld = 1'(isld);
    v.av = 1'(av); v.ard = 5'(ard); v.adata = adata;
    v.lv = 1'(lv); v.ldata = ldata;
    v.eir = 1'(eir); v.elr = 1'(elr); v.ewe = 1'(ewe); v.ewa = 5'(ewa); v.ewd = ewd;
    v.elo = elo; v.eidle = 1'(eidle);
    return v;
  endfunction

  task automatic set_nop();
    issue_valid = 1'b0; issue_rs0 = 5'd0; issue_rs1 = 5'd0; issue_rd = 5'd0;
    issue_writes_rd = 1'b0; issue_is_load = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_resp_valid = 1'b0; ld_resp_data = 32'd0;
  endtask

  task automatic apply(input vec_t v);
    issue_valid = v.iv; issue_rs0 = v.rs0; issue_rs1 = v.rs1; issue_rd = v.rd;
    issue_writes_rd = v.wrd; issue_is_load = v.isld;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
    ld_resp_valid = v.lv; ld_resp_data = v.ldata;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_issue_ready"}, 32'(issue_ready), 32'(e_ir));
    chk({tag, "_ld_resp_ready"}, 32'(ld_resp_ready), 32'(e_lr));
    chk({tag, "_wr_ena"}, 32'(wr_ena), 32'(e_we));
    if (e_we) begin
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(e_wa));
      chk({tag, "_wr_data"}, wr_data, e_wd);
    end
    chk({tag, "_loads_outstanding"}, 32'(loads_outstanding), 32'(e_lo));
    chk({tag, "_idle"}, 32'(idle), 32'(e_idle));
  endtask

  vec_t tbl [$];

  initial begin
    // A: ALU path
    tbl.push_back(mk(1,1,2,5,1,0, 0,0,0,            0,0,            1,0,0,0,0,           0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 1,5,32'hAA,       0,0,            1,0,1,5,32'hAA,      0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,            0,0,            1,0,0,0,0,           0,1));
    // B: RAW stall behind load x7
    tbl.push_back(mk(1,0,0,7,1,1, 0,0,0,            0,0,            1,0,0,0,0,           0,1));
    tbl.push_back(mk(1,7,0,8,1,0, 0,0,0,            0,0,            0,1,0,0,0,           1,0));
    tbl.push_back(mk(1,7,0,8,1,0, 0,0,0,            1,32'h12345678, 0,1,1,7,32'h12345678,1,0));
    tbl.push_back(mk(1,7,0,8,1,0, 0,0,0,            0,0,            1,0,0,0,0,           0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 1,8,32'h88,       0,0,            1,0,1,8,32'h88,      0,0));
    // C: load queue full
    tbl.push_back(mk(1,0,0,1,1,1, 0,0,0,            0,0,            1,0,0,0,0,           0,1));
    tbl.push_back(mk(1,0,0,2,1,1, 0,0,0,            0,0,            1,1,0,0,0,           1,0));
    tbl.push_back(mk(1,0,0,3,1,1, 0,0,0,            0,0,            1,1,0,0,0,           2,0));
    tbl.push_back(mk(1,0,0,4,1,1, 0,0,0,            0,0,            1,1,0,0,0,           3,0));
    tbl.push_back(mk(1,0,0,10,1,1,0,0,0,            0,0,            0,1,0,0,0,           4,0));
    tbl.push_back(mk(1,11,12,13,1,0,0,0,0,          0,0,            1,1,0,0,0,           4,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,            1,32'h11,       1,1,1,1,32'h11,      4,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,            1,32'h22,       1,1,1,2,32'h22,      3,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,            1,32'h33,       1,1,1,3,32'h33,      2,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,            1,32'h44,       1,1,1,4,32'h44,      1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,13,32'hD,       0,0,            1,0,1,13,32'hD,      0,0));
    // D: ALU / load port conflict
    tbl.push_back(mk(1,0,0,9,1,0, 0,0,0,            0,0,            1,0,0,0,0,           0,1));
    tbl.push_back(mk(1,0,0,6,1,1, 0,0,0,            0,0,            1,0,0,0,0,           0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,9,32'h99,       1,32'h66,       1,0,1,9,32'h99,      1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,            1,32'h66,       1,1,1,6,32'h66,      1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,            0,0,            1,0,0,0,0,           0,1));
    // E: load to x0, WAW stall, ALU to x0, response with empty FIFO
    tbl.push_back(mk(1,0,0,0,1,1, 0,0,0,            0,0,            1,0,0,0,0,           0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,            1,32'hDEAD,     1,1,0,0,0,           1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,            0,0,            1,0,0,0,0,           0,1));
    tbl.push_back(mk(1,0,0,3,1,0, 0,0,0,            0,0,            1,0,0,0,0,           0,1));
    tbl.push_back(mk(1,0,0,3,1,0, 0,0,0,            0,0,            0,0,0,0,0,           0,0));
    tbl.push_back(mk(1,0,0,3,1,0, 1,3,32'h3,        0,0,            0,0,1,3,32'h3,       0,0));
    tbl.push_back(mk(1,0,0,3,1,0, 0,0,0,            0,0,            1,0,0,0,0,           0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 1,3,32'h30,       0,0,            1,0,1,3,32'h30,      0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,32'h5,        0,0,            1,0,0,0,0,           0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,            1,32'hBAD,      1,0,0,0,0,           0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,            0,0,            1,0,0,0,0,           0,1));

    // ---------------- reset state ----------------
    rst = 1'b1;
    set_nop();
    issue_valid = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h55;
    @(negedge clk);
    chk("rst_issue_ready", 32'(issue_ready), 32'd0);
    chk("rst_ld_resp_ready", 32'(ld_resp_ready), 32'd0);
    chk("rst_wr_ena", 32'(wr_ena), 32'd0);
    chk("rst_loads_outstanding", 32'(loads_outstanding), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_nop();
    model_reset();

    // ---------------- directed table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d_issue_ready", i), 32'(issue_ready), 32'(tbl[i].eir));
      chk($sformatf("row%0d_ld_resp_ready", i), 32'(ld_resp_ready), 32'(tbl[i].elr));
      chk($sformatf("row%0d_wr_ena", i), 32'(wr_ena), 32'(tbl[i].ewe));
      if (tbl[i].ewe) begin
        chk($sformatf("row%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].ewa));
        chk($sformatf("row%0d_wr_data", i), wr_data, tbl[i].ewd);
      end
      chk($sformatf("row%0d_loads_outstanding", i), 32'(loads_outstanding), 32'(tbl[i].elo));
      chk($sformatf("row%0d_idle", i), 32'(idle), 32'(tbl[i].eidle));
      model_eval();
      model_commit();
      @(posedge clk); #1;
    end

    // ---------------- async reset with two loads outstanding ----------------
    for (int i = 0; i < 2; i++) begin
      set_nop();
      issue_valid = 1'b1; issue_rd = 5'(20 + i); issue_writes_rd = 1'b1; issue_is_load = 1'b1;
      @(negedge clk);
      model_eval();
      model_commit();
      @(posedge clk); #1;
    end
    set_nop();
    #1;
    chk("pre_rst_loads_outstanding", 32'(loads_outstanding), 32'd2);
    chk("pre_rst_ld_resp_ready", 32'(ld_resp_ready), 32'd1);
    chk("pre_rst_idle", 32'(idle), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_loads_outstanding", 32'(loads_outstanding), 32'd0);
    chk("async_rst_idle", 32'(idle), 32'd1);
    chk("async_rst_issue_ready", 32'(issue_ready), 32'd0);
    chk("async_rst_ld_resp_ready", 32'(ld_resp_ready), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    ld_resp_valid = 1'b1; ld_resp_data = 32'hCAFE;
    #1;
    chk("late_resp_ld_resp_ready", 32'(ld_resp_ready), 32'd0);
    chk("late_resp_wr_ena", 32'(wr_ena), 32'd0);
    @(posedge clk); #1;
    chk("late_resp_loads_outstanding", 32'(loads_outstanding), 32'd0);
    chk("late_resp_idle", 32'(idle), 32'd1);
    set_nop();

    // ---------------- randomized traffic vs model ----------------
    for (int cyc = 0; cyc < 3000; cyc++) begin
      issue_valid     = ($urandom_range(0, 3) != 0);
      issue_rs0       = 5'($urandom_range(0, 7));
      issue_rs1       = 5'($urandom_range(0, 7));
      issue_rd        = 5'($urandom_range(0, 7));
      issue_writes_rd = ($urandom_range(0, 3) != 0);
      issue_is_load   = ($urandom_range(0, 2) == 0);
      if (alu_pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        alu_valid = 1'b1;
        alu_rd    = 5'(alu_pend[$urandom_range(0, alu_pend.size() - 1)]);
      end else if ($urandom_range(0, 15) == 0) begin
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
      end else begin
        alu_valid = 1'b0;
        alu_rd    = 5'($urandom_range(0, 31));
      end
      alu_data      = $urandom;
      ld_resp_valid = ($urandom_range(0, 1) == 1);
      ld_resp_data  = $urandom;
      @(negedge clk);
      model_eval();
      check_model("rnd");
      model_commit();
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
